// File: rtl/instr_encoder_if.sv
// Field stream into the encoder and the instruction-memory write port out of it.
// master drives the fields and im_stall; slave is the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [2:0]        in_cls;
  logic [2:0]        in_alu;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              im_stall;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output in_valid, in_last, in_cls, in_alu, in_rs, in_rt, in_rd, in_imm, in_target, im_stall,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_valid, in_last, in_cls, in_alu, in_rs, in_rt, in_rd, in_imm, in_target, im_stall,
    output in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// Instruction-memory loader: encodes MIPS fields, buffers them in a small FIFO and
// writes them to consecutive IM addresses, holding the CPU until the program is in.
module instr_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  instr_encoder_if.slave  bus,
  output logic            cpu_hold,
  output logic            done,
  output logic            err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t            state;
  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] addr, addr_next;
  logic [31:0]       word;
  logic [5:0]        funct;
  logic              legal, fifo_full, fifo_empty;
  logic              accept, push, pop, complete;

  always_comb begin
    funct = 6'h00;
    legal = 1'b1;
    word  = 32'h0;
    case (bus.in_alu)
      3'd0:    funct = 6'h20;
      3'd1:    funct = 6'h22;
      3'd2:    funct = 6'h24;
      3'd3:    funct = 6'h25;
      3'd4:    funct = 6'h2A;
      default: funct = 6'h00;
    endcase
    case (bus.in_cls)
      3'd0: begin
        word  = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'h00, funct};
        legal = (bus.in_alu <= 3'd4);
      end
      3'd1:    word = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd2:    word = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd3:    word = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd4:    word = {6'h02, bus.in_target};
      3'd5:    word = {6'h0D, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd6:    word = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm};
      default: legal = 1'b0;
    endcase
  end

  assign fifo_full    = (count == (PTR_W+1)'(DEPTH));
  assign fifo_empty   = (count == '0);
  assign bus.in_ready = (state == LOAD) && !fifo_full;
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && legal;
  assign complete     = bus.im_we && !bus.im_stall;
  // A completing write frees the port on the same edge, so the next word follows back-to-back.
  assign pop          = !fifo_empty && (!bus.im_we || !bus.im_stall);
  assign addr_next    = complete ? addr + ADDR_W'(1) : addr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      addr         <= BASE;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= BASE;
      bus.im_wdata <= 32'h0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);

      if (complete) begin
        addr <= addr_next;
        if (addr == '1) err <= 1'b1;
      end
      if (pop) begin
        bus.im_we    <= 1'b1;
        bus.im_addr  <= addr_next;
        bus.im_wdata <= mem[rd_ptr];
      end else if (complete) begin
        bus.im_we <= 1'b0;
      end
      if (accept && !legal) err <= 1'b1;

      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          addr  <= BASE;
          err   <= 1'b0;
        end
        LOAD: if (accept && bus.in_last) state <= DRAIN;
        DRAIN: if (fifo_empty && !bus.im_we) begin
          state    <= DONE;
          done     <= 1'b1;
          cpu_hold <= 1'b0;
        end
        DONE: if (start) begin
          state    <= LOAD;
          done     <= 1'b0;
          cpu_hold <= 1'b1;
          addr     <= BASE;
          err      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded words, stall, illegal fields, wrap, reset, restart.
module tb_instr_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic hold0, done0, err0, hold1, done1, err1;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] la0[$], ld0[$], la1[$], ld1[$];

  instr_encoder_if #(.ADDR_W(8)) i0 ();
  instr_encoder_if #(.ADDR_W(8)) i1 ();

  instr_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .bus(i0.slave),
    .cpu_hold(hold0), .done(done0), .err(err0));
  instr_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(254)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bus(i1.slave),
    .cpu_hold(hold1), .done(done1), .err(err1));

  always #5 clk = ~clk;

  // Inputs change only #1 after posedge, so what is seen at negedge is what the next edge uses.
  always @(negedge clk) begin
    if (rst_n && i0.im_we && !i0.im_stall) begin la0.push_back(32'(i0.im_addr)); ld0.push_back(i0.im_wdata); end
    if (rst_n && i1.im_we && !i1.im_stall) begin la1.push_back(32'(i1.im_addr)); ld1.push_back(i1.im_wdata); end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start0();
    start0 = 1'b1; tick(); start0 = 1'b0;
  endtask

  task automatic set_fields(input logic [2:0] cls, input logic [2:0] alu, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                            input logic [25:0] tgt, input logic last);
    i0.in_cls = cls; i0.in_alu = alu; i0.in_rs = rs; i0.in_rt = rt; i0.in_rd = rd;
    i0.in_imm = imm; i0.in_target = tgt; i0.in_last = last;
  endtask

  task automatic send(input logic [2:0] cls, input logic [2:0] alu, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic last);
    logic acc;
    int n;
    set_fields(cls, alu, rs, rt, rd, imm, tgt, last);
    i0.in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = i0.in_ready;
      tick();
      n++;
    end
    i0.in_valid = 1'b0;
    i0.in_last = 1'b0;
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send_ori(input logic [4:0] r, input logic [15:0] imm, input logic last);
    send(3'd5, 3'd0, 5'd0, r, 5'd0, imm, 26'd0, last);
  endtask

  function automatic logic [31:0] ori_word(input int r, input int imm);
    return 32'h3400_0000 | (32'(r) << 16) | 32'(imm);
  endfunction

  task automatic wait_done0(input string tag);
    int n = 0;
    while (!done0 && n < 100) begin @(negedge clk); n++; end
    chk(tag, 32'(done0), 32'd1);
  endtask

  initial begin
    i0.in_valid = 0; i0.im_stall = 0; set_fields(0, 0, 0, 0, 0, 0, 0, 0);
    i1.in_valid = 0; i1.im_stall = 0; i1.in_last = 0; i1.in_cls = 0; i1.in_alu = 0;
    i1.in_rs = 0; i1.in_rt = 0; i1.in_rd = 0; i1.in_imm = 0; i1.in_target = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", 32'(hold0), 32'd1);
    chk("rst_we", 32'(i0.im_we), 32'd0);
    chk("rst_ready_done_err", {29'd0, i0.in_ready, done0, err0}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(i0.in_ready), 32'd0);

    // 1: add, sub, lw; first-word latency
    la0.delete(); ld0.delete();
    pulse_start0();
    send(3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
    @(negedge clk);
    chk("t1_lat_we0", 32'(i0.im_we), 32'd0);
    tick();
    chk("t1_lat_we1", 32'(i0.im_we), 32'd1);
    chk("t1_lat_data", i0.im_wdata, 32'h0022_1820);
    send(3'd0, 3'd1, 5'd3, 5'd1, 5'd5, 16'd0, 26'd0, 1'b0);
    send(3'd1, 3'd0, 5'd0, 5'd4, 5'd0, 16'd8, 26'd0, 1'b1);
    wait_done0("t1_done");
    chk("t1_hold", 32'(hold0), 32'd0);
    chk("t1_count", 32'(la0.size()), 32'd3);
    if (la0.size() == 3) begin
      chk("t1_a0", la0[0], 32'd0); chk("t1_d0", ld0[0], 32'h0022_1820);
      chk("t1_a1", la0[1], 32'd1); chk("t1_d1", ld0[1], 32'h0061_2822);
      chk("t1_a2", la0[2], 32'd2); chk("t1_d2", ld0[2], 32'h8C04_0008);
    end

    // 2: stall, FIFO fill, hold stable
    begin
      int acc_n = 0;
      int k = 1;
      la0.delete(); ld0.delete();
      i0.im_stall = 1'b1;
      pulse_start0();
      send_ori(5'd0, 16'd0, 1'b0);
      tick();
      set_fields(3'd5, 3'd0, 5'd0, 5'(k), 5'd0, 16'(k), 26'd0, 1'b0);
      i0.in_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (i0.in_ready) acc_n++;
        chk("t2_hold_we", 32'(i0.im_we), 32'd1);
        chk("t2_hold_addr", 32'(i0.im_addr), 32'd0);
        chk("t2_hold_data", i0.im_wdata, ori_word(0, 0));
        if (i0.in_ready) begin
          tick(); k++;
          set_fields(3'd5, 3'd0, 5'd0, 5'(k), 5'd0, 16'(k), 26'd0, 1'b0);
        end else tick();
      end
      i0.in_valid = 1'b0;
      chk("t2_accepts", 32'(acc_n), 32'd4);
      chk("t2_ready_low", 32'(i0.in_ready), 32'd0);
      i0.im_stall = 1'b0;
      send_ori(5'd5, 16'd5, 1'b1);
      wait_done0("t2_done");
      chk("t2_count", 32'(la0.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
        if (i < la0.size()) begin
          chk("t2_addr", la0[i], 32'(i));
          chk("t2_data", ld0[i], ori_word(i, i));
        end
      end
    end

    // 3: illegal cls and alu skipped
    la0.delete(); ld0.delete();
    pulse_start0();
    chk("t3_err_clr", 32'(err0), 32'd0);
    send(3'd6, 3'd0, 5'd0, 5'd1, 5'd0, 16'd5, 26'd0, 1'b0);
    send(3'd7, 3'd0, 5'd1, 5'd1, 5'd1, 16'd1, 26'd0, 1'b0);
    send(3'd3, 3'd0, 5'd1, 5'd2, 5'd0, 16'd3, 26'd0, 1'b0);
    send(3'd0, 3'd5, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
    send(3'd2, 3'd0, 5'd1, 5'd2, 5'd0, 16'd4, 26'd0, 1'b1);
    wait_done0("t3_done");
    chk("t3_err", 32'(err0), 32'd1);
    chk("t3_count", 32'(la0.size()), 32'd3);
    if (la0.size() == 3) begin
      chk("t3_d0", ld0[0], 32'h2001_0005);
      chk("t3_a1", la0[1], 32'd1); chk("t3_d1", ld0[1], 32'h1022_0003);
      chk("t3_a2", la0[2], 32'd2); chk("t3_d2", ld0[2], 32'hAC22_0004);
    end

    // 6: restart from DONE, jump encoding
    la0.delete(); ld0.delete();
    pulse_start0();
    chk("t6_hold", 32'(hold0), 32'd1);
    chk("t6_done", 32'(done0), 32'd0);
    chk("t6_err", 32'(err0), 32'd0);
    send(3'd4, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h000_0010, 1'b1);
    wait_done0("t6_done2");
    chk("t6_count", 32'(la0.size()), 32'd1);
    if (la0.size() == 1) begin
      chk("t6_addr", la0[0], 32'd0);
      chk("t6_data", ld0[0], 32'h0800_0010);
    end

    // 4: address wrap on the second instance
    begin
      int k = 0;
      int n = 0;
      la1.delete(); ld1.delete();
      start1 = 1'b1; tick(); start1 = 1'b0;
      i1.in_cls = 3'd5; i1.in_rt = 5'd1; i1.in_imm = 16'd1; i1.in_last = 1'b0;
      i1.in_valid = 1'b1;
      while (k < 3 && n < 50) begin
        @(negedge clk);
        if (i1.in_ready) begin
          tick(); k++;
          i1.in_rt = 5'(k + 1); i1.in_imm = 16'(k + 1); i1.in_last = (k == 2);
        end else tick();
        n++;
      end
      i1.in_valid = 1'b0; i1.in_last = 1'b0;
      chk("t4_accepts", 32'(k), 32'd3);
      n = 0;
      while (!done1 && n < 100) begin @(negedge clk); n++; end
      chk("t4_done", 32'(done1), 32'd1);
      chk("t4_err", 32'(err1), 32'd1);
      chk("t4_count", 32'(la1.size()), 32'd3);
      if (la1.size() == 3) begin
        chk("t4_a0", la1[0], 32'd254); chk("t4_d0", ld1[0], ori_word(1, 1));
        chk("t4_a1", la1[1], 32'd255);
        chk("t4_a2", la1[2], 32'd0);   chk("t4_d2", ld1[2], ori_word(3, 3));
      end
    end

    // 5: reset with words in flight
    i0.im_stall = 1'b1;
    pulse_start0();
    send_ori(5'd1, 16'd1, 1'b0);
    send_ori(5'd2, 16'd2, 1'b0);
    send_ori(5'd3, 16'd3, 1'b0);
    chk("t5_pre_we", 32'(i0.im_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_we", 32'(i0.im_we), 32'd0);
    chk("t5_hold", 32'(hold0), 32'd1);
    chk("t5_ready", 32'(i0.in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    i0.im_stall = 1'b0;
    la0.delete(); ld0.delete();
    repeat (10) tick();
    chk("t5_no_writes", 32'(la0.size()), 32'd0);
    chk("t5_idle", {30'd0, done0, i0.in_ready}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
